// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit WISC pipeline: opcodes, flag bit positions
// and the helpers that decide which condition codes an opcode writes.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_RED    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Adder ops write all three condition codes.
    function automatic logic sets_zvn(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Logic and shift ops write only Z; V and N keep their previous value.
    function automatic logic sets_z(input logic [3:0] op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// Architectural condition-code register {Z,V,N}; writes are masked per opcode.
module flag_reg
    import wisc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       v,
    input  logic       n,
    output logic [2:0] flags
);

    logic [2:0] flags_q;
    logic [2:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (en) begin
            if (sets_zvn(op)) begin
                flags_d[FLAG_Z] = zero;
                flags_d[FLAG_V] = v;
                flags_d[FLAG_N] = n;
            end else if (sets_z(op)) begin
                flags_d[FLAG_Z] = zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the executed instruction, owns the
// condition codes and a sticky RUN/HALTED state that squashes everything after HLT.
module ex_mem_stage
    import wisc_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_alu_out,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic          ex_halt,
    input  logic          ex_flag_v,
    input  logic          ex_flag_n,
    output logic          mem_valid,
    output logic [3:0]    mem_opcode,
    output logic [DW-1:0] mem_alu_out,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_write,
    output logic          mem_mem_read,
    output logic          mem_mem_write,
    output logic [2:0]    flags,
    output logic          fwd_en,
    output logic          halted
);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_HALTED = 1'b1;

    logic          state_q, state_d;
    logic          valid_q, valid_d;
    logic [3:0]    opcode_q, opcode_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] sdata_q, sdata_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          rw_q, rw_d;
    logic          mr_q, mr_d;
    logic          mw_q, mw_d;

    logic bubble;
    logic capture;
    logic flag_en;

    // Once halted, every cycle behaves like a flush regardless of stall.
    assign bubble  = (state_q == ST_HALTED) || flush;
    assign capture = !bubble && !stall;
    assign flag_en = capture && ex_valid;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        alu_d    = alu_q;
        sdata_d  = sdata_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        if (bubble) begin
            valid_d  = 1'b0;
            opcode_d = ex_opcode;
            alu_d    = ex_alu_out;
            sdata_d  = ex_store_data;
            rd_d     = ex_rd;
            rw_d     = 1'b0;
            mr_d     = 1'b0;
            mw_d     = 1'b0;
        end else if (capture) begin
            valid_d  = ex_valid;
            opcode_d = ex_opcode;
            alu_d    = ex_alu_out;
            sdata_d  = ex_store_data;
            rd_d     = ex_rd;
            rw_d     = ex_reg_write;
            mr_d     = ex_mem_read;
            mw_d     = ex_mem_write;
            // HLT retires with no architectural side effects.
            if (ex_valid && ex_halt) begin
                rw_d    = 1'b0;
                mw_d    = 1'b0;
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            alu_q    <= '0;
            sdata_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            alu_q    <= alu_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
        end
    end

    flag_reg u_flag_reg (
        .clk   (clk),
        .rst   (rst),
        .en    (flag_en),
        .op    (ex_opcode),
        .zero  (ex_alu_out == '0),
        .v     (ex_flag_v),
        .n     (ex_flag_n),
        .flags (flags)
    );

    assign mem_valid      = valid_q;
    assign mem_opcode     = opcode_q;
    assign mem_alu_out    = alu_q;
    assign mem_store_data = sdata_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = rw_q;
    assign mem_mem_read   = mr_q;
    assign mem_mem_write  = mw_q;
    assign fwd_en         = valid_q && rw_q && !mr_q;
    assign halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios then random traffic, all cycles
// scored against a behavioural model through an expected-output queue.
module tb_ex_mem_stage;

    localparam int W = 49;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_alu_out, ex_store_data;
    logic [3:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_halt, ex_flag_v, ex_flag_n;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_alu_out, mem_store_data;
    logic [3:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic [2:0]  flags;
    logic        fwd_en, halted;

    ex_mem_stage #(.DW(16), .RW(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_halt(ex_halt),
        .ex_flag_v(ex_flag_v), .ex_flag_n(ex_flag_n),
        .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_alu_out(mem_alu_out),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .flags(flags), .fwd_en(fwd_en), .halted(halted)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // Behavioural model of the architectural state seen downstream of EX.
    logic        m_valid = 0, m_rw = 0, m_mr = 0, m_mw = 0, m_halted = 0;
    logic [3:0]  m_op = 0, m_rd = 0;
    logic [15:0] m_alu = 0, m_sd = 0;
    logic        m_z = 0, m_v = 0, m_n = 0;

    function automatic logic [W-1:0] pack_dut();
        return {mem_valid, mem_opcode, mem_alu_out, mem_store_data, mem_rd,
                mem_reg_write, mem_mem_read, mem_mem_write, flags, fwd_en, halted};
    endfunction

    task automatic model_step();
        if (rst) begin
            {m_valid, m_rw, m_mr, m_mw, m_halted} = '0;
            m_op = 0; m_rd = 0; m_alu = 0; m_sd = 0;
            {m_z, m_v, m_n} = 3'b000;
        end else if (m_halted || flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            m_op = ex_opcode; m_alu = ex_alu_out; m_sd = ex_store_data; m_rd = ex_rd;
        end else if (!stall) begin
            m_valid = ex_valid; m_op = ex_opcode; m_alu = ex_alu_out;
            m_sd = ex_store_data; m_rd = ex_rd;
            m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write;
            if (ex_valid && ex_halt) begin
                m_rw = 0; m_mw = 0; m_halted = 1;
            end
            if (ex_valid) begin
                case (ex_opcode)
                    4'd0, 4'd1: begin m_z = (ex_alu_out == 0); m_v = ex_flag_v; m_n = ex_flag_n; end
                    4'd3, 4'd4, 4'd5, 4'd6: m_z = (ex_alu_out == 0);
                    default: ;
                endcase
            end
        end
        exp_q.push_back({m_valid, m_op, m_alu, m_sd, m_rd, m_rw, m_mr, m_mw,
                         m_z, m_v, m_n, m_valid & m_rw & ~m_mr, m_halted});
    endtask

    // Driver: inputs change on the falling edge; returns just after the rising edge.
    task automatic cyc(input logic r, input logic s, input logic f, input logic v,
                       input logic [3:0] op, input logic [15:0] alu, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic hl,
                       input logic fv, input logic fn);
        @(negedge clk);
        rst = r; stall = s; flush = f; ex_valid = v; ex_opcode = op; ex_alu_out = alu;
        ex_store_data = 16'($urandom); ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
        ex_mem_write = mw; ex_halt = hl; ex_flag_v = fv; ex_flag_n = fn;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one registered output set per cycle, compared with the queue head.
    initial begin
        logic [W-1:0] exp;
        logic [W-1:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = pack_dut();
                n_tests++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got %h expected %h", $time, act, exp);
                end
            end
        end
    end

    initial begin
        logic [3:0] op;
        logic       r;
        rst = 1; stall = 0; flush = 0; ex_valid = 0; ex_opcode = 0; ex_alu_out = 0;
        ex_store_data = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_halt = 0; ex_flag_v = 0; ex_flag_n = 0;
        cyc(1, 0, 0, 0, 4'd0, 16'h0, 4'd0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 4'd0, 16'h1234, 4'd3, 1, 0, 0, 0, 1, 1);
        // Reset with a valid ADD presented
        cyc(1, 0, 0, 1, 4'd0, 16'h1234, 4'd3, 1, 0, 0, 0, 1, 1);
        check("rst_valid", {15'd0, mem_valid}, 16'd0);
        check("rst_alu", mem_alu_out, 16'd0);
        check("rst_flags", {13'd0, flags}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        // ADD zero with overflow, then XOR nonzero
        cyc(0, 0, 0, 1, 4'd0, 16'h0000, 4'd1, 1, 0, 0, 0, 1, 0);
        check("add_flags", {13'd0, flags}, 16'b110);
        cyc(0, 0, 0, 1, 4'd3, 16'h0001, 4'd2, 1, 0, 0, 0, 1, 1);
        check("xor_flags", {13'd0, flags}, 16'b010);
        // SUB negative, then stalled XOR zero
        cyc(0, 0, 0, 1, 4'd1, 16'h0005, 4'd4, 1, 0, 0, 0, 0, 1);
        check("sub_flags", {13'd0, flags}, 16'b001);
        cyc(0, 1, 0, 1, 4'd3, 16'h0000, 4'd6, 1, 0, 0, 0, 1, 0);
        check("stall_flags", {13'd0, flags}, 16'b001);
        check("stall_alu", mem_alu_out, 16'h0005);
        check("stall_op", {12'd0, mem_opcode}, 16'd1);
        // Flush and stall with a valid LW
        cyc(0, 1, 1, 1, 4'd8, 16'h0040, 4'd5, 1, 1, 0, 0, 0, 0);
        check("flush_valid", {15'd0, mem_valid}, 16'd0);
        check("flush_mr", {15'd0, mem_mem_read}, 16'd0);
        check("flush_flags", {13'd0, flags}, 16'b001);
        // Set flags to 101, then PADDSB with zero result
        cyc(0, 0, 0, 1, 4'd1, 16'h0000, 4'd7, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 4'd7, 16'h0000, 4'd7, 1, 0, 0, 0, 1, 0);
        check("paddsb_flags", {13'd0, flags}, 16'b101);
        check("paddsb_alu", mem_alu_out, 16'h0000);
        check("paddsb_fwd", {15'd0, fwd_en}, 16'd1);
        // HLT, then a squashed ADD, then reset
        cyc(0, 0, 0, 1, 4'd15, 16'h0000, 4'd9, 1, 0, 1, 1, 1, 1);
        check("hlt_halted", {15'd0, halted}, 16'd1);
        check("hlt_valid", {15'd0, mem_valid}, 16'd1);
        check("hlt_rw", {15'd0, mem_reg_write}, 16'd0);
        check("hlt_mw", {15'd0, mem_mem_write}, 16'd0);
        cyc(0, 0, 0, 1, 4'd0, 16'h0000, 4'd1, 1, 0, 0, 0, 0, 0);
        check("halt_squash", {15'd0, mem_valid}, 16'd0);
        check("halt_flags", {13'd0, flags}, 16'b101);
        cyc(1, 0, 0, 0, 4'd0, 16'h0000, 4'd0, 0, 0, 0, 0, 0, 0);
        check("rst_clears_halt", {15'd0, halted}, 16'd0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            op = 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 39) == 0);
            cyc(r, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) != 0, op,
                ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                (op == 4'd15) && ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
        end
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
